gradient_xy: RTL

Spatial-gradient stage directly downstream of convolutionFilter in the Horn-Schunck optical-flow pipeline. It consumes the smoothed 8-bit raster stream (one pixel per cycle, frame_sync on the first pixel) and produces signed horizontal (Ix) and vertical (Iy) first differences per pixel. It also forwards the pixel, aligned with the gradients, for the temporal-derivative stage. A single-line buffer sized for the maximum image width holds the previous row.

---
 rtl/gradient_xy.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gradient_xy.sv
// gradient_xy: spatial-gradient stage of the optical-flow pipeline.
// It takes a raster stream of unsigned pixels and produces, two cycles later,
// the signed horizontal (Ix) and vertical (Iy) first differences of each pixel,
// together with the pixel itself and a frame-start marker.
// A single line buffer holds the previous row for the vertical difference.
//
// Ports:
//   clk                clock, all state on the rising edge
//   reset              asynchronous, active-low reset
//   io_image_width     image width minus 1
//   io_image_height    image height minus 1
//   io_frame_sync_in   high with pixel (0,0); also aborts a running frame
//   io_data_in         pixel stream, one pixel per cycle while running
//   io_frame_sync_out  high with the outputs of pixel (0,0)
//   io_data_out        pixel aligned with the gradients
//   io_ix_out          two's-complement horizontal difference
//   io_iy_out          two's-complement vertical difference
//
// state | meaning
// IDLE  | waiting for io_frame_sync_in, input ignored
// RUN   | one pixel consumed every cycle at (col_q,row_q)
module gradient_xy #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM_WIDTH  = 10,
  parameter int MAX_WIDTH  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIM_WIDTH-1:0]  io_image_width,
  input  logic [DIM_WIDTH-1:0]  io_image_height,
  input  logic                  io_frame_sync_in,
  input  logic [DATA_WIDTH-1:0] io_data_in,
  output logic                  io_frame_sync_out,
  output logic [DATA_WIDTH-1:0] io_data_out,
  output logic [DATA_WIDTH:0]   io_ix_out,
  output logic [DATA_WIDTH:0]   io_iy_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q;
  logic [DIM_WIDTH-1:0]  col_q, row_q;

  // stage 1
  logic                  s1_valid_q, s1_sync_q, s1_col0_q, s1_row0_q;
  logic [DATA_WIDTH-1:0] s1_p_q, s1_prev_q;
  logic [DATA_WIDTH-1:0] lb_rd_q;

  // line buffer, deliberately without reset: row 0 never uses its contents
  logic [DATA_WIDTH-1:0] linebuf_q [MAX_WIDTH];

  // stage 2 / outputs
  logic                  sync_out_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH:0]   ix_q, iy_q;

  logic                  in_valid;
  logic [DIM_WIDTH-1:0]  cur_col, cur_row;
  logic                  col_last, last_px;
  logic [DATA_WIDTH:0]   ix_d, iy_d;

  // A sync always starts a new frame at (0,0), even in the middle of one.
  assign in_valid = io_frame_sync_in || (state_q == RUN);
  assign cur_col  = io_frame_sync_in ? '0 : col_q;
  assign cur_row  = io_frame_sync_in ? '0 : row_q;
  assign col_last = (cur_col == io_image_width);
  assign last_px  = col_last && (cur_row == io_image_height);

  always_comb begin
    ix_d = '0;
    iy_d = '0;
    if (!s1_col0_q) ix_d = {1'b0, s1_p_q} - {1'b0, s1_prev_q};
    if (!s1_row0_q) iy_d = {1'b0, s1_p_q} - {1'b0, lb_rd_q};
  end

  // Read-before-write: the same-address read returns the previous row.
  always_ff @(posedge clk) begin
    lb_rd_q <= linebuf_q[cur_col];
    if (in_valid) linebuf_q[cur_col] <= io_data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_sync_q  <= 1'b0;
      s1_col0_q  <= 1'b0;
      s1_row0_q  <= 1'b0;
      s1_p_q     <= '0;
      s1_prev_q  <= '0;
      sync_out_q <= 1'b0;
      data_out_q <= '0;
      ix_q       <= '0;
      iy_q       <= '0;
    end else begin
      // control
      if (in_valid) begin
        if (last_px) begin
          state_q <= IDLE;
          col_q   <= '0;
          row_q   <= '0;
        end else begin
          state_q <= RUN;
          if (col_last) begin
            col_q <= '0;
            row_q <= cur_row + 1'b1;
          end else begin
            col_q <= cur_col + 1'b1;
            row_q <= cur_row;
          end
        end
      end

      // stage 1
      s1_valid_q <= in_valid;
      s1_sync_q  <= io_frame_sync_in;
      s1_col0_q  <= (cur_col == '0);
      s1_row0_q  <= (cur_row == '0);
      if (in_valid) begin
        s1_p_q    <= io_data_in;
        s1_prev_q <= s1_p_q;
      end

      // stage 2
      if (s1_valid_q) begin
        sync_out_q <= s1_sync_q;
        data_out_q <= s1_p_q;
        ix_q       <= ix_d;
        iy_q       <= iy_d;
      end else begin
        sync_out_q <= 1'b0;
        data_out_q <= '0;
        ix_q       <= '0;
        iy_q       <= '0;
      end
    end
  end

  assign io_frame_sync_out = sync_out_q;
  assign io_data_out       = data_out_q;
  assign io_ix_out         = ix_q;
  assign io_iy_out         = iy_q;

endmodule
